// File: rtl/five_bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice plus carry flop, LSB first, ready/start in, valid/ack out.
// Optional macro ADD_SAT_EN: clamp sum to all ones when the final carry is set (cout still reports 1).
module five_bit_serial_adder #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             valid,
    input  logic             ack,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_sr, b_sr, sum_q;
    logic             carry_q, cout_q;
    logic [CNT_W-1:0] cnt_q;

    logic             s_bit, c_next, last_bit;
    logic [WIDTH-1:0] sum_shift, sum_final;

`ifdef ADD_SAT_EN
    function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH-1:0] s, input logic c);
        return c ? {WIDTH{1'b1}} : s;
    endfunction
`endif

    // Single full-adder slice working on the operand LSBs
    assign s_bit     = a_sr[0] ^ b_sr[0] ^ carry_q;
    assign c_next    = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry_q) | (b_sr[0] & carry_q);
    assign sum_shift = {s_bit, sum_q[WIDTH-1:1]};
    assign last_bit  = (cnt_q == LAST_BIT);

    always_comb begin
`ifdef ADD_SAT_EN
        sum_final = sat_sum(sum_shift, c_next);
`else
        sum_final = sum_shift;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  if (ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                    end
                end
                S_RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    carry_q <= c_next;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    // Final bit also captures the carry-out and, if enabled, the clamped sum
                    if (last_bit) begin
                        sum_q  <= sum_final;
                        cout_q <= c_next;
                    end else begin
                        sum_q  <= sum_shift;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready = (state_q == S_IDLE);
    assign busy  = (state_q == S_RUN);
    assign valid = (state_q == S_DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;

endmodule

// File: tb/tb_five_bit_serial_adder.sv
// Scoreboard bench for five_bit_serial_adder: stimulus pushes expected {cout,sum}, a monitor checks each result.
module tb_five_bit_serial_adder;

    localparam int W = 5;

`ifdef ADD_SAT_EN
    localparam logic [W-1:0] OVF_SUM = 5'd31;
`else
    localparam logic [W-1:0] OVF_SUM = 5'd0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         ack = 1'b0;
    logic         ready, busy, valid, cout;
    logic [W-1:0] sum;

    int tests = 0;
    int fails = 0;

    logic [W:0] exp_q[$];

    five_bit_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .valid (valid),
        .ack   (ack),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pop on the first valid cycle, then hold the same expectation while valid stays high
    initial begin : monitor
        logic [W:0] cur;
        logic       prev_valid;
        logic       have;
        prev_valid = 1'b0;
        have = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                have = 1'b0;
            end else begin
                if (valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        have = 1'b0;
                        $display("FAIL unexpected_valid: got sum=%0d cout=%0d, expected no result", sum, cout);
                    end else begin
                        cur = exp_q.pop_front();
                        have = 1'b1;
                    end
                end
                if (valid && have) check("result", {27'd0, cout, sum}, {27'd0, cur});
                prev_valid = valid;
            end
        end
    end

    task automatic wait_ready();
        int g;
        g = 0;
        while (!ready && g < 30) begin
            @(negedge clk);
            g++;
        end
        check("ready_wait", {31'd0, ready}, 32'd1);
    endtask

    // Issues one operation, checks latency, optionally stalls ack while toggling inputs, then acks
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         input logic [W:0] exp, input int hold);
        int n;
        int g;
        wait_ready();
        a = av; b = bv; cin = cv; start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1 start = 1'b0;
        n = 0; g = 0;
        @(negedge clk);
        while (!valid && g < 30) begin
            if (busy) n++;
            g++;
            @(negedge clk);
        end
        check("latency", n, W);
        check("valid_seen", {31'd0, valid}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            a = W'($urandom); b = W'($urandom); start = ~start;
            @(negedge clk);
            check("hold_valid", {31'd0, valid}, 32'd1);
        end
        start = 1'b0;
        ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        @(negedge clk);
        check("ready_after_ack", {31'd0, ready}, 32'd1);
        check("valid_after_ack", {31'd0, valid}, 32'd0);
        check("sum_retained", {27'd0, sum}, {27'd0, exp[W-1:0]});
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int g;
        logic seen;
        // Reset state
        #2;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_sum",   {27'd0, sum},   32'd0);
        check("rst_cout",  {31'd0, cout},  32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        do_op(5'd9,  5'd5,  1'b0, {1'b0, 5'd14}, 0);
        do_op(5'd31, 5'd1,  1'b0, {1'b1, OVF_SUM}, 0);
        do_op(5'd3,  5'd4,  1'b1, {1'b0, 5'd8}, 0);
        do_op(5'd31, 5'd31, 1'b1, {1'b1, 5'd31}, 0);

        // Start ignored during RUN and when it coincides with ack in DONE
        wait_ready();
        a = 5'd2; b = 5'd2; cin = 1'b0; start = 1'b1;
        exp_q.push_back({1'b0, 5'd4});
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 begin a = 5'd10; b = 5'd10; start = 1'b1; end
        @(posedge clk);
        #1 start = 1'b0;
        g = 0;
        @(negedge clk);
        while (!valid && g < 30) begin
            g++;
            @(negedge clk);
        end
        check("dup_valid", {31'd0, valid}, 32'd1);
        start = 1'b1; ack = 1'b1;
        @(posedge clk);
        #1 begin start = 1'b0; ack = 1'b0; end
        @(negedge clk);
        check("dup_ready", {31'd0, ready}, 32'd1);
        repeat (2) @(negedge clk);
        check("dup_no_launch", {31'd0, busy}, 32'd0);
        check("dup_still_ready", {31'd0, ready}, 32'd1);

        // Reset in the middle of an operation discards it
        wait_ready();
        a = 5'd20; b = 5'd7; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, ready}, 32'd1);
        check("mid_rst_busy",  {31'd0, busy},  32'd0);
        check("mid_rst_valid", {31'd0, valid}, 32'd0);
        check("mid_rst_sum",   {27'd0, sum},   32'd0);
        check("mid_rst_cout",  {31'd0, cout},  32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (valid || busy) seen = 1'b1;
        end
        check("no_valid_after_rst", {31'd0, seen}, 32'd0);
        do_op(5'd20, 5'd7, 1'b0, {1'b0, 5'd27}, 0);

        // Long ack stall with toggling inputs
        do_op(5'd17, 5'd6, 1'b1, {1'b0, 5'd24}, 10);

        // ack while idle does nothing
        ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        @(negedge clk);
        check("idle_ack_ready", {31'd0, ready}, 32'd1);
        check("idle_ack_busy",  {31'd0, busy},  32'd0);
        check("idle_ack_valid", {31'd0, valid}, 32'd0);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
